// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply, restoring divide; stalls EX until a one-cycle result strobe.
module ex_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iEn,
    input  logic            iStart,
    input  logic [2:0]      iFunc3,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    input  logic            iFlush,
    output logic            oStall,
    output logic            oBusy,
    output logic            oDone,
    output logic [XLEN-1:0] oResult
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            func_q, func_d;
    logic                  neg_q, neg_d;
    logic [XLEN-1:0]       op_q, op_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]       res_q, res_d;

    // Operand decode at issue
    logic            signed_a, signed_b, a_neg, b_neg, is_div, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;

    always_comb begin
        signed_a = (iFunc3 == 3'b001) || (iFunc3 == 3'b010) ||
                   (iFunc3 == 3'b100) || (iFunc3 == 3'b110);
        signed_b = (iFunc3 == 3'b001) || (iFunc3 == 3'b100) || (iFunc3 == 3'b110);
        a_neg    = signed_a & iA[XLEN-1];
        b_neg    = signed_b & iB[XLEN-1];
        a_mag    = a_neg ? -iA : iA;
        b_mag    = b_neg ? -iB : iB;
        is_div   = iFunc3[2];
        div_zero = is_div && (iB == '0);
        div_ovf  = is_div && !iFunc3[0] && (iA == {1'b1, {(XLEN-1){1'b0}}}) && (iB == '1);
        if (div_zero) begin
            spec_res = iFunc3[1] ? iA : '1;
        end else begin
            spec_res = iFunc3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of each datapath; acc holds {hi, lo} for multiply, {rem, quot} for divide
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, op_q};
        if (div_trial[XLEN]) begin
            div_next = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        div_sel  = func_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_fix  = neg_q ? -div_sel : div_sel;
        if (func_q[2]) begin
            fix_res = div_fix;
        end else if (func_q[1:0] == 2'b00) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        neg_d   = neg_q;
        op_d    = op_q;
        acc_d   = acc_q;
        res_d   = res_q;
        if (iFlush) begin
            state_d = StIdle;
        end else if (iEn) begin
            unique case (state_q)
                StIdle: begin
                    if (iStart) begin
                        func_d = iFunc3;
                        // REM follows the dividend sign; everything else the operand XOR
                        neg_d  = (is_div && iFunc3[1]) ? a_neg : (a_neg ^ b_neg);
                        if (div_zero || div_ovf) begin
                            res_d   = spec_res;
                            state_d = StDone;
                        end else begin
                            op_d    = is_div ? b_mag : a_mag;
                            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            cnt_d   = '0;
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_d = func_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    res_d   = fix_res;
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            func_q  <= '0;
            neg_q   <= 1'b0;
            op_q    <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign oStall  = ((state_q == StIdle) && iStart) || (state_q == StCalc) ||
                     (state_q == StFix);
    assign oBusy   = (state_q != StIdle);
    assign oDone   = (state_q == StDone);
    assign oResult = res_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: vector table plus directed reset/flush/enable/chaining cases.
module tb_ex_muldiv_seq;

    logic        iClk = 1'b0;
    logic        iRst, iEn, iStart, iFlush;
    logic [2:0]  iFunc3;
    logic [31:0] iA, iB;
    logic        oStall, oBusy, oDone;
    logic [31:0] oResult;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iStart (iStart),
        .iFunc3 (iFunc3),
        .iA     (iA),
        .iB     (iB),
        .iFlush (iFlush),
        .oStall (oStall),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oResult(oResult)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model built from plain 64-bit and int arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b}; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hffffffff;
                if (a == 32'h80000000 && b == 32'hffffffff) return 32'h80000000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hffffffff : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hffffffff) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hffffffff))) return 1;
        return 34;
    endfunction

    task automatic watch_no_done(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(posedge iClk); #1;
            if (oDone) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    // Called at posedge+1 with the DUT idle; cycle 0 is the issue cycle.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit chain, input int fz_lo, input int fz_hi);
        int cyc = 0;
        int stall_err = 0;
        int done_cyc = -1;
        logic [31:0] e;
        iStart = 1'b1;
        iFunc3 = f3;
        iA     = a;
        iB     = b;
        sb_q.push_back(exp);
        while (1) begin
            iEn = !(cyc >= fz_lo && cyc <= fz_hi);
            #1;
            if (oStall !== (cyc < lat)) stall_err++;
            if (oDone) begin
                done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check({name, " unexpected done"}, 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({name, " result"}, oResult, e);
                end
                if (!chain) iStart = 1'b0;
                break;
            end
            if (cyc > lat + 20) begin
                check({name, " timeout"}, 32'(cyc), 32'(lat));
                break;
            end
            @(posedge iClk); #1;
            cyc++;
        end
        iEn = 1'b1;
        check({name, " latency"}, 32'(done_cyc), 32'(lat));
        check({name, " stall"}, 32'(stall_err), 32'd0);
        @(posedge iClk); #1;
        check({name, " single done"}, 32'(oDone), 32'd0);
        check({name, " idle after"}, 32'(oBusy), 32'd0);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'hffffffff, 32'h2, 32'hfffffffe, 34};
        vecs[1]  = '{3'd1, 32'hffffffff, 32'h2, 32'hffffffff, 34};
        vecs[2]  = '{3'd3, 32'hffffffff, 32'h2, 32'h00000001, 34};
        vecs[3]  = '{3'd2, 32'hffffffff, 32'h2, 32'hffffffff, 34};
        vecs[4]  = '{3'd4, 32'hfffffff9, 32'h2, 32'hfffffffd, 34};
        vecs[5]  = '{3'd6, 32'hfffffff9, 32'h2, 32'hffffffff, 34};
        vecs[6]  = '{3'd5, 32'hfffffff9, 32'h2, 32'h7ffffffc, 34};
        vecs[7]  = '{3'd7, 32'hfffffff9, 32'h2, 32'h00000001, 34};
        vecs[8]  = '{3'd5, 32'h5, 32'h0, 32'hffffffff, 1};
        vecs[9]  = '{3'd6, 32'h5, 32'h0, 32'h00000005, 1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hffffffff, 32'h00000000, 1};
        vecs[12] = '{3'd7, 32'h80000000, 32'hffffffff, 32'h80000000, 34};
        vecs[13] = '{3'd2, 32'h80000000, 32'hffffffff, 32'h80000000, 34};

        iRst = 1'b1; iEn = 1'b1; iStart = 1'b0; iFlush = 1'b0;
        iFunc3 = '0; iA = '0; iB = '0;
        repeat (3) @(posedge iClk);
        #1;
        check("reset busy", 32'(oBusy), 32'd0);
        check("reset done", 32'(oDone), 32'd0);
        check("reset result", oResult, 32'd0);
        check("reset stall", 32'(oStall), 32'd0);
        iRst = 1'b0;
        @(posedge iClk); #1;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].lat, 1'b0, 1, 0);
        end

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : $urandom >> (i * 3);
            run_op($sformatf("rnd%0d", i), rf, ra, rb, model(rf, ra, rb), lat_of(rf, ra, rb),
                   1'b0, 1, 0);
        end

        // Reset mid-CALC
        run_op("pre-reset", 3'd3, 32'hffffffff, 32'h2, 32'h1, 34, 1'b0, 1, 0);
        iStart = 1'b1; iFunc3 = 3'd0; iA = 32'd7; iB = 32'd6;
        repeat (10) begin @(posedge iClk); #1; end
        iRst = 1'b1; iStart = 1'b0;
        @(posedge iClk); #1;
        check("midcalc reset busy", 32'(oBusy), 32'd0);
        check("midcalc reset result", oResult, 32'd0);
        check("midcalc reset stall", 32'(oStall), 32'd0);
        iRst = 1'b0;
        watch_no_done("midcalc reset no done", 40);

        // Flush mid-operation
        iStart = 1'b1; iFunc3 = 3'd4; iA = 32'hfffffff9; iB = 32'd2;
        repeat (5) begin @(posedge iClk); #1; end
        iFlush = 1'b1; iStart = 1'b0;
        @(posedge iClk); #1;
        iFlush = 1'b0;
        check("flush idle", 32'(oBusy), 32'd0);
        watch_no_done("flush no done", 40);

        // Start and flush together: not accepted
        iStart = 1'b1; iFlush = 1'b1; iFunc3 = 3'd0; iA = 32'd3; iB = 32'd3;
        @(posedge iClk); #1;
        iStart = 1'b0; iFlush = 1'b0;
        check("start+flush idle", 32'(oBusy), 32'd0);
        watch_no_done("start+flush no done", 40);

        // Enable frozen for cycles 3..12 pushes the strobe out by ten cycles
        run_op("freeze div", 3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd, 44, 1'b0, 3, 12);

        // Back-to-back with iStart held through DONE
        run_op("b2b first", 3'd0, 32'hffffffff, 32'd2, 32'hfffffffe, 34, 1'b1, 1, 0);
        run_op("b2b second", 3'd5, 32'hfffffff9, 32'd2, 32'h7ffffffc, 34, 1'b1, 1, 0);
        run_op("b2b special", 3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, 1, 1'b1, 1, 0);
        run_op("b2b last", 3'd7, 32'd100, 32'd7, 32'd2, 34, 1'b0, 1, 0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
